multi_fi: RTL and testbench
===========================

// Module: multi_fi
// PURPOSE
//  Sequential unsigned multiplier using repeated addition.
//  Operands arrive one after the other on a single shared input bus.
//  Product is P = A*B, formed by adding A to an accumulator B times.
//  Standalone arithmetic block with a start/done handshake.
// PARAMETERS
//  WIDTH  16  Operand, accumulator and product width in bits.
// PORTS
//  clk       in   1      Rising-edge clock; the only clock.
//  rst       in   1      Reset, asynchronous, active-high.
//  data_in   in   WIDTH  Operand bus: A first, then B.
//  start     in   1      Sampled at clk edges; starts an operation.
//  data_out  out  WIDTH  Product accumulator P, continuously driven.
//  done      out  1      High while the result is valid.
// BEHAVIOUR
//  Registers: A, B (down-counter) and P, each WIDTH bits, plus the FSM state.
//  Reset (async, rst=1): state=IDLE; A=B=P=0; data_out=0; done=0.
//  FSM, one transition per rising clk edge:
//   IDLE:   start=1 -> LOAD_A; otherwise stay.
//   LOAD_A: A<=data_in -> LOAD_B.
//   LOAD_B: B<=data_in; P<=0 -> ADD.
//   ADD:    B!=0: P<=P+A, B<=B-1; if B==1 go to DONE on the same edge.
//           B==0 on entry (zero multiplier): -> DONE with P=0.
//   DONE:   hold P; start=1 -> LOAD_A (new operation); otherwise stay.
//  Timing: edge E0 samples start. A is taken at E1 and B at E2.
//  For B>0, done rises after edge E2+B; for B==0, after E3.
//  done = (state==DONE); it is a level output, not a pulse.
//  Arithmetic: unsigned; P wraps modulo 2^WIDTH and overflow is silently dropped.
//  start is ignored in LOAD_A, LOAD_B and ADD.
//  data_in is ignored except at the LOAD_A and LOAD_B edges.
//  Operands must be valid at their capture edges; the bench must time them to those edges.
//  rst asserted mid-operation: immediate return to IDLE, all registers cleared.
//  P is visible on data_out during accumulation; it is meaningful only when done=1.
// CONFIGURATION
//  MULTI_FI_ZERO_SKIP_EN defined:
//   - In LOAD_B, if A==0 or data_in==0, load P<=0 and go directly to DONE.
//   - done rises after E2 (one cycle earlier than the B==0 path above).
//   - A==0 with a large B therefore costs no ADD cycles.
//  Not defined: behaviour is exactly as above.
//   - A==0 runs B additions of zero; the final P is 0.
// TESTING
//  1. Reset: assert rst with no clk edge -> data_out=0, done=0, FSM in IDLE.
//  2. A=4, B=3 -> data_out=12; done rises after E5 and holds while start=0.
//  3. A=7, B=0 -> data_out=0; done after E3 (after E2 with ZERO_SKIP_EN).
//  4. A=0x0100, B=0x0100 -> data_out=0x0000 (wrap).
//     A=0xFFFF, B=2 -> data_out=0xFFFE.
//  5. Pulse start during ADD with A=5, B=4 -> ignored, result 20.
//     Then start in DONE, with A=2, B=9 -> data_out=18.
//  6. rst pulse in ADD, A=3, B=10 -> immediate data_out=0, done=0.
//     Then a fresh run, A=6, B=6 -> data_out=36.

Source files
------------

// File: rtl/multi_fi.sv
// multi_fi - sequential unsigned multiplier built from repeated addition.
//
// Operand A, then operand B, arrive one after the other on data_in. P = A*B is
// formed by adding A into an accumulator B times. Arithmetic wraps modulo 2^WIDTH.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   data_in   in   WIDTH  operand bus: A at the LOAD_A edge, B at the LOAD_B edge
//   start     in   1      starts an operation (honoured in IDLE and DONE only)
//   data_out  out  WIDTH  product accumulator, continuously driven
//   done      out  1      level, high while the FSM is in DONE
//
// Configuration macro: MULTI_FI_ZERO_SKIP_EN
//   When defined, a zero A or zero B at the LOAD_B edge jumps straight to DONE
//   with P=0 and no ADD cycles. When undefined, zero operands run the normal path.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// LOAD_A | capture A from data_in on the next edge
// LOAD_B | capture B from data_in, clear P
// ADD    | P += A and B -= 1 per edge until B reaches zero
// DONE   | P valid and held; start begins a new operation

module multi_fi #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_p_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_p_nxt     = r_p;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        w_a_nxt     = data_in;
        w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_b_nxt     = data_in;
        w_p_nxt     = '0;
        w_state_nxt = S_ADD;
`ifdef MULTI_FI_ZERO_SKIP_EN
        // Product is known to be zero: skip the accumulation entirely.
        if ((r_a == '0) || (data_in == '0)) w_state_nxt = S_DONE;
`endif
      end
      S_ADD: begin
        if (r_b != '0) begin
          w_p_nxt = r_p + r_a;
          w_b_nxt = r_b - 1'b1;
          // Last addition happens on this edge, so leave ADD together with it.
          if (r_b == {{(WIDTH-1){1'b0}}, 1'b1}) w_state_nxt = S_DONE;
        end else begin
          // Zero multiplier: P was cleared in LOAD_B, nothing to add.
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) w_state_nxt = S_LOAD_A;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_out = r_p;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_multi_fi.sv
module tb_multi_fi;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         start;
  logic [W-1:0] data_out;
  logic         done;

  int n_vec;
  int n_err;

  multi_fi #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .start    (start),
    .data_out (data_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           pulse;
    logic [W-1:0] exp_p;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: product mod 2^W, and edges after the B-capture edge until done.
  function automatic logic [W-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned prod;
    prod = longint'(a) * longint'(b);
    return prod[W-1:0];
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTI_FI_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 0;
`endif
    return (b == 0) ? 1 : int'(b);
  endfunction

  // Called #1 after a rising edge with FSM in IDLE or DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse,
                        input logic [W-1:0] exp_p, input int exp_lat, input string tag);
    int lat;
    logic [W-1:0] held;
    start = 1'b1;
    @(posedge clk); #1;            // E0
    start   = 1'b0;
    data_in = a;
    @(posedge clk); #1;            // E1
    data_in = b;
    @(posedge clk); #1;            // E2
    data_in = W'($urandom);
    if (pulse) start = 1'b1;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      start   = 1'b0;
      data_in = W'($urandom);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " product"}, data_out, exp_p);
    held = data_out;
    repeat (3) begin
      @(posedge clk); #1;
      data_in = W'($urandom);
    end
    chk({tag, " done held"}, done, 1);
    chk({tag, " product held"}, data_out, held);
  endtask

  initial begin
    vecs[0] = '{a: 16'd4,      b: 16'd3,      pulse: 1'b0, exp_p: 16'd12,     exp_lat: 3};
`ifdef MULTI_FI_ZERO_SKIP_EN
    vecs[1] = '{a: 16'd7,      b: 16'd0,      pulse: 1'b0, exp_p: 16'd0,      exp_lat: 0};
`else
    vecs[1] = '{a: 16'd7,      b: 16'd0,      pulse: 1'b0, exp_p: 16'd0,      exp_lat: 1};
`endif
    vecs[2] = '{a: 16'h0100,   b: 16'h0100,   pulse: 1'b0, exp_p: 16'h0000,   exp_lat: 256};
    vecs[3] = '{a: 16'hFFFF,   b: 16'd2,      pulse: 1'b0, exp_p: 16'hFFFE,   exp_lat: 2};
    vecs[4] = '{a: 16'd5,      b: 16'd4,      pulse: 1'b1, exp_p: 16'd20,     exp_lat: 4};
    vecs[5] = '{a: 16'd2,      b: 16'd9,      pulse: 1'b0, exp_p: 16'd18,     exp_lat: 9};

    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;

    // Reset with no clock edge yet.
    #2;
    chk("reset data_out", data_out, 0);
    chk("reset done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle stays idle", done, 0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].pulse, vecs[i].exp_p, vecs[i].exp_lat,
             $sformatf("vec%0d", i));

    // Reset in the middle of accumulation.
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = 16'd3;
    @(posedge clk); #1;
    data_in = 16'd10;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-add partial P", data_out, 12);
    chk("mid-add not done", done, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst data_out", data_out, 0);
    chk("async rst done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post-rst idle", done, 0);
    run_op(16'd6, 16'd6, 1'b0, 16'd36, 6, "after rst 6x6");

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = 16'hFFFF;
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : W'($urandom_range(1, 40));
      run_op(ra, rb, 1'b0, model_p(ra, rb), model_lat(ra, rb), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
